// File: rtl/cf_wb_irq_gclk_ctrl.sv
// Wishbone page-0xFFxx front-end for CF peripherals: IM/MIS/RIS/ICR interrupt block,
// clock-gate enable register with scan override and a wait-state ack sequencer.
module cf_wb_irq_gclk_ctrl #(
    parameter int unsigned NUM_IRQ    = 9,
    parameter logic [31:0] EDGE_MASK  = 32'h1FE,
    parameter int unsigned ACK_WAIT   = 0,
    parameter logic        GCLK_RESET = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [15:0]        adr_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    input  logic [3:0]         sel_i,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    output logic               ack_o,
    output logic               hit_o,
    input  logic [NUM_IRQ-1:0] flags_i,
    input  logic               sc_testmode,
    output logic               clk_gated_en_o,
    output logic               irq_o
);

    localparam logic [31:0] IRQ_MASK  = 32'((64'd1 << NUM_IRQ) - 64'd1);
    localparam logic [31:0] EDGE_BITS = EDGE_MASK & IRQ_MASK;
    localparam logic [3:0]  WAIT_INIT = (ACK_WAIT == 0) ? 4'd0 : 4'(ACK_WAIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] im_q;
    logic [31:0] ris_q;
    logic [31:0] flag_q;
    logic        gclk_q;

    logic [31:0] flags_w;
    logic [31:0] byte_mask;
    logic [31:0] ris;
    logic [31:0] mis;
    logic [31:0] edge_set;
    logic [31:0] icr_clr;
    logic        valid;
    logic        commit;
    logic        im_we;
    logic        icr_we;
    logic        gclk_we;

    always_comb begin
        flags_w = '0;
        flags_w[NUM_IRQ-1:0] = flags_i;
        for (int unsigned i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{sel_i[i]}};
        end
    end

    assign hit_o          = (adr_i[15:8] == 8'hFF);
    assign valid          = cyc_i & stb_i & hit_o;
    assign ack_o          = (state_q == ST_ACK);
    assign commit         = ack_o & valid & we_i;
    assign im_we          = commit && (adr_i[7:0] == 8'h00);
    assign icr_we         = commit && (adr_i[7:0] == 8'h0C);
    assign gclk_we        = commit && (adr_i[7:0] == 8'h10) && sel_i[0];
    assign clk_gated_en_o = sc_testmode | gclk_q;

    // Level bits follow the live flag; only edge bits are held in ris_q.
    assign ris      = (ris_q & EDGE_BITS) | (flags_w & ~EDGE_BITS);
    assign mis      = ris & im_q;
    assign edge_set = flags_w & ~flag_q & EDGE_BITS;
    assign icr_clr  = icr_we ? (dat_i & byte_mask) : '0;

    always_comb begin
        dat_o = 32'hDEADBEEF;
        case (adr_i[7:0])
            8'h00:   dat_o = im_q;
            8'h04:   dat_o = mis;
            8'h08:   dat_o = ris;
            8'h0C:   dat_o = '0;
            8'h10:   dat_o = {31'd0, gclk_q};
            default: dat_o = 32'hDEADBEEF;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        if (ACK_WAIT == 0) begin
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cyc_i || !stb_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            im_q   <= '0;
            ris_q  <= '0;
            flag_q <= '0;
            gclk_q <= GCLK_RESET;
            irq_o  <= 1'b0;
        end else begin
            flag_q <= flags_w;
            irq_o  <= |mis;
            // A clear and a new edge on the same cycle leave the bit set.
            ris_q  <= ((ris_q & ~icr_clr) | edge_set) & EDGE_BITS;
            if (im_we) begin
                im_q <= ((im_q & ~byte_mask) | (dat_i & byte_mask)) & IRQ_MASK;
            end
            if (gclk_we) begin
                gclk_q <= dat_i[0];
            end
        end
    end

endmodule
